// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: IF/ID/EX/MEM/WB sequencing with registered state and IR, combinational control outputs.
// Latency: j 2, beq/bne 3, ALU ops and sw 4, lw 5 cycles; stalls in IF on Inst_Valid and in MEM on Mem_Ready.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Req,
    input  logic        Mem_Ready,
    input  logic        Zero,
    output logic [2:0]  ALUop,
    output logic [4:0]  sa,
    output logic [31:0] IR,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        ST_RST = 3'd0,
        ST_IF  = 3'd1,
        ST_ID  = 3'd2,
        ST_EX  = 3'd3,
        ST_MEM = 3'd4,
        ST_WB  = 3'd5
    } state_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype, is_addiu, is_lui, is_lw, is_sw, is_beq, is_bne, is_j;
    logic       r_legal, is_legal;
    logic [2:0] r_aluop;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign is_rtype = (opcode == 6'b000000);
    assign is_j     = (opcode == 6'b000010);
    assign is_beq   = (opcode == 6'b000100);
    assign is_bne   = (opcode == 6'b000101);
    assign is_addiu = (opcode == 6'b001001);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);

    always_comb begin
        r_aluop = ALU_ADD;
        r_legal = 1'b1;
        case (funct)
            6'b100001: r_aluop = ALU_ADD;
            6'b100011: r_aluop = ALU_SUB;
            6'b100100: r_aluop = ALU_AND;
            6'b100101: r_aluop = ALU_OR;
            6'b101010: r_aluop = ALU_SLT;
            6'b101011: r_aluop = ALU_SLTU;
            6'b000000: r_aluop = ALU_SLL;
            default:   r_legal = 1'b0;
        endcase
    end

    assign is_legal = (is_rtype && r_legal) || is_addiu || is_lui || is_lw ||
                      is_sw || is_beq || is_bne || is_j;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_RST: state_d = ST_IF;
            ST_IF: begin
                if (Inst_Valid) begin
                    state_d = ST_ID;
                    ir_d    = Instruction;
                end
            end
            // Illegal encodings retire as a NOP straight from decode.
            ST_ID:  state_d = (is_j || !is_legal) ? ST_IF : ST_EX;
            ST_EX: begin
                if (is_lw || is_sw)
                    state_d = ST_MEM;
                else if (is_rtype || is_addiu || is_lui)
                    state_d = ST_WB;
                else
                    state_d = ST_IF;
            end
            ST_MEM: begin
                if (Mem_Ready)
                    state_d = is_lw ? ST_WB : ST_IF;
            end
            ST_WB:  state_d = ST_IF;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        Inst_Req = 1'b0;
        ALUop    = ALU_ADD;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        Illegal  = 1'b0;
        case (state_q)
            ST_RST: ALUop = 3'b000;
            ST_IF: begin
                Inst_Req = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = Inst_Valid;
                PCWrite  = Inst_Valid;
            end
            // Branch target is precomputed here so EX can load it from ALUOut.
            ST_ID: begin
                ALUSrcB = 2'b11;
                Illegal = !is_legal;
                if (is_j) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
            end
            ST_EX: begin
                if (is_rtype) begin
                    ALUSrcA = 1'b1;
                    ALUop   = r_aluop;
                end else if (is_addiu || is_lui) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUop   = is_lui ? ALU_LUI : ALU_ADD;
                end else if (is_lw || is_sw) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end else if (is_beq || is_bne) begin
                    ALUSrcA  = 1'b1;
                    ALUop    = ALU_SUB;
                    PCSource = 2'b01;
                    PCWrite  = is_beq ? Zero : !Zero;
                end
            end
            ST_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype;
                MemtoReg = is_lw;
            end
            default: ALUop = ALU_ADD;
        endcase
    end

    assign IR = ir_q;
    assign sa = ir_q[10:6];

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver queues the expected per-cycle control word of each
// instruction, and a negedge monitor pops and compares whenever the controller is not idling in IF.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        resetn;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Req;
    logic        Mem_Ready;
    logic        Zero;
    logic [2:0]  ALUop;
    logic [4:0]  sa;
    logic [31:0] IR;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, MemtoReg, Illegal;

    mc_ctrl_fsm dut (
        .clk(clk), .resetn(resetn), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
        .Inst_Req(Inst_Req), .Mem_Ready(Mem_Ready), .Zero(Zero), .ALUop(ALUop), .sa(sa),
        .IR(IR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        inst_req, ir_write, pc_write, reg_write, mem_read, mem_write, illegal;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  pc_source;
        logic        reg_dst, mem_to_reg;
        logic [2:0]  alu_op;
        logic [4:0]  sa;
        logic [31:0] ir;
    } obs_t;

    localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LW = 3'd2, C_SW = 3'd3;
    localparam logic [2:0] C_BEQ = 3'd4, C_BNE = 3'd5, C_J = 3'd6, C_ILL = 3'd7;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [2:0]  aluop;
        logic        zero;
        logic [3:0]  inst_wait;
        logic [3:0]  mem_wait;
    } vec_t;

    obs_t  exp_q[$];
    obs_t  msk_q[$];
    string tag_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    vec_t  vecs[22];
    obs_t  act, e_m, m_m;
    string t_m;

    function automatic obs_t strobe_mask();
        obs_t m;
        m = '0;
        m.inst_req = 1'b1; m.ir_write = 1'b1; m.pc_write = 1'b1; m.reg_write = 1'b1;
        m.mem_read = 1'b1; m.mem_write = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    task automatic push(input obs_t e, input obs_t m, input string tag);
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    // Expected control word for every non-idle cycle of one instruction.
    task automatic expect_instr(input vec_t v);
        obs_t e, m;
        e = '0; m = strobe_mask();
        e.inst_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.alu_src_b = 2'b01; e.alu_op = 3'b010;
        m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1; m.pc_source = '1;
        push(e, m, "if_accept");

        e = '0; m = strobe_mask();
        e.alu_src_b = 2'b11; e.alu_op = 3'b010; e.ir = v.instr; e.sa = v.instr[10:6];
        m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_op = '1; m.ir = '1; m.sa = '1;
        if (v.cls == C_J) begin
            e.pc_write = 1'b1; e.pc_source = 2'b10; m.pc_source = '1;
        end
        if (v.cls == C_ILL) e.illegal = 1'b1;
        push(e, m, "id");
        if (v.cls == C_J || v.cls == C_ILL) return;

        e = '0; m = strobe_mask();
        e.ir = v.instr; e.sa = v.instr[10:6]; e.alu_op = v.aluop;
        m.ir = '1; m.sa = '1; m.alu_op = '1; m.alu_src_b = '1;
        case (v.cls)
            C_R: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; m.alu_src_a = 1'b1; end
            C_I: e.alu_src_b = 2'b10;
            C_LW, C_SW: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; m.alu_src_a = 1'b1; end
            default: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; m.alu_src_a = 1'b1;
                e.pc_source = 2'b01; m.pc_source = '1;
                e.pc_write = (v.cls == C_BEQ) ? v.zero : !v.zero;
            end
        endcase
        push(e, m, "ex");
        if (v.cls == C_BEQ || v.cls == C_BNE) return;

        if (v.cls == C_LW || v.cls == C_SW) begin
            for (int k = 0; k <= int'(v.mem_wait); k++) begin
                e = '0; m = strobe_mask();
                e.mem_read = (v.cls == C_LW); e.mem_write = (v.cls == C_SW);
                e.alu_op = 3'b010; e.ir = v.instr; m.alu_op = '1; m.ir = '1;
                push(e, m, "mem");
            end
            if (v.cls == C_SW) return;
        end

        e = '0; m = strobe_mask();
        e.reg_write = 1'b1; e.reg_dst = (v.cls == C_R); e.mem_to_reg = (v.cls == C_LW);
        e.alu_op = 3'b010; e.ir = v.instr;
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; m.alu_op = '1; m.ir = '1;
        push(e, m, "wb");
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Advance one cycle and scatter strobes where the controller must ignore them.
    task automatic tick();
        @(posedge clk);
        #1;
        Inst_Valid  = !Inst_Req ? 1'($urandom_range(0, 1)) : 1'b0;
        Mem_Ready   = !(MemRead || MemWrite) ? 1'($urandom_range(0, 1)) : 1'b0;
        Instruction = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input int abort_at);
        int guard;
        guard = 0;
        while (!Inst_Req && guard < 100) begin tick(); guard++; end
        if (!Inst_Req) begin
            n_vec++; n_fail++;
            $display("FAIL fetch_timeout: got Inst_Req=0 want 1 for instr %h", v.instr);
            return;
        end
        for (int w = 0; w < int'(v.inst_wait); w++) tick();
        expect_instr(v);
        Instruction = v.instr;
        Inst_Valid  = 1'b1;
        Zero        = v.zero;
        tick();
        if (v.cls == C_LW || v.cls == C_SW) begin
            guard = 0;
            while (!(MemRead || MemWrite) && guard < 20) begin tick(); guard++; end
            if (!(MemRead || MemWrite)) begin
                n_vec++; n_fail++;
                $display("FAIL mem_timeout: got no MemRead/MemWrite want one for instr %h", v.instr);
                return;
            end
            for (int k = 0; k <= int'(v.mem_wait); k++) begin
                if (k == abort_at) begin
                    check("abort_premise_memwrite", 64'(MemWrite), 64'd1);
                    resetn = 1'b0;
                    #1;
                    check("abort_strobes", 64'({PCWrite, RegWrite, MemWrite, MemRead, IRWrite}), 64'd0);
                    check("abort_ir", 64'(IR), 64'd0);
                    exp_q.delete(); msk_q.delete(); tag_q.delete();
                    return;
                end
                Mem_Ready = (k == int'(v.mem_wait));
                tick();
            end
        end
    endtask

    task automatic release_reset();
        push('0, '1, "rst_state");
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            act = '{Inst_Req, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Illegal, ALUSrcA,
                    ALUSrcB, PCSource, RegDst, MemtoReg, ALUop, sa, IR};
            n_vec++;
            if ($countones({PCWrite, RegWrite, MemWrite}) > 1) begin
                n_fail++;
                $display("FAIL write_onehot: got %b want at most one set", {PCWrite, RegWrite, MemWrite});
            end
            n_vec++;
            if (Inst_Req && !IRWrite) begin
                if (PCWrite || ALUSrcB != 2'b01) begin
                    n_fail++;
                    $display("FAIL if_wait: got PCWrite=%b ALUSrcB=%b want 0 01", PCWrite, ALUSrcB);
                end
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cycle: got %h want idle IF", act);
            end else begin
                e_m = exp_q.pop_front();
                m_m = msk_q.pop_front();
                t_m = tag_q.pop_front();
                if ((act & m_m) !== (e_m & m_m))
                    begin
                        n_fail++;
                        $display("FAIL %s: got %h want %h (mask %h)", t_m, act, e_m, m_m);
                    end
            end
        end
    end

    initial begin
        int guard;
        resetn = 1'b1; Instruction = '0; Inst_Valid = 1'b0; Mem_Ready = 1'b0; Zero = 1'b0;
        vecs[0]  = '{32'h00221821, C_R,   3'b010, 1'b0, 4'd3, 4'd0}; // addu
        vecs[1]  = '{32'h10220003, C_BEQ, 3'b110, 1'b1, 4'd0, 4'd0};
        vecs[2]  = '{32'h10220003, C_BEQ, 3'b110, 1'b0, 4'd1, 4'd0};
        vecs[3]  = '{32'h14220003, C_BNE, 3'b110, 1'b1, 4'd0, 4'd0};
        vecs[4]  = '{32'h14220003, C_BNE, 3'b110, 1'b0, 4'd2, 4'd0};
        vecs[5]  = '{32'h8C220004, C_LW,  3'b010, 1'b0, 4'd0, 4'd3}; // MemRead for 4 cycles
        vecs[6]  = '{32'hAC220004, C_SW,  3'b010, 1'b0, 4'd1, 4'd2};
        vecs[7]  = '{32'h00221963, C_R,   3'b110, 1'b0, 4'd0, 4'd0}; // subu sa=5
        vecs[8]  = '{32'h00221964, C_R,   3'b000, 1'b0, 4'd0, 4'd0}; // and
        vecs[9]  = '{32'h00221965, C_R,   3'b001, 1'b0, 4'd0, 4'd0}; // or
        vecs[10] = '{32'h0022196A, C_R,   3'b101, 1'b0, 4'd0, 4'd0}; // slt
        vecs[11] = '{32'h0022196B, C_R,   3'b100, 1'b0, 4'd0, 4'd0}; // sltu
        vecs[12] = '{32'h00221940, C_R,   3'b111, 1'b0, 4'd0, 4'd0}; // sll sa=5
        vecs[13] = '{32'h00221961, C_R,   3'b010, 1'b0, 4'd0, 4'd0}; // addu sa=5
        vecs[14] = '{32'h24220005, C_I,   3'b010, 1'b0, 4'd0, 4'd0}; // addiu
        vecs[15] = '{32'h3C021234, C_I,   3'b011, 1'b0, 4'd0, 4'd0}; // lui
        vecs[16] = '{32'h08000010, C_J,   3'b010, 1'b0, 4'd0, 4'd0}; // j
        vecs[17] = '{32'hFC000000, C_ILL, 3'b010, 1'b0, 4'd0, 4'd0}; // opcode 0x3F
        vecs[18] = '{32'h00221808, C_ILL, 3'b010, 1'b0, 4'd0, 4'd0}; // unsupported funct
        vecs[19] = '{32'h00000000, C_R,   3'b111, 1'b0, 4'd0, 4'd0}; // sll nop
        vecs[20] = '{32'h8C220004, C_LW,  3'b010, 1'b0, 4'd0, 4'd0};
        vecs[21] = '{32'hAC220004, C_SW,  3'b010, 1'b0, 4'd0, 4'd9}; // aborted by reset

        #2 resetn = 1'b0;
        #1;
        check("reset_outputs", 64'({Inst_Req, IRWrite, PCWrite, RegWrite, MemRead, MemWrite,
                                    Illegal, ALUop, IR}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        release_reset();

        for (int i = 0; i < 21; i++) run_vec(vecs[i], -1);

        run_vec(vecs[21], 2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_ir", 64'(IR), 64'd0);
        release_reset();
        run_vec(vecs[0], -1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin @(posedge clk); guard++; end
        if (exp_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending cycles want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle main controller for the MIPS CPU. It fetches and holds the current instruction, sequences it through fetch, decode, execute, memory and write-back states, and on every cycle drives the ALU's `ALUop`/`sa` inputs, the datapath mux selects and the register/memory/PC write strobes. It closes the loop with the ALU by consuming the ALU `Zero` flag for branches. It sits between instruction/data memory handshakes and the datapath that instantiates the ALU.

## Interface

- no parameters; data width fixed at 32
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `Instruction`  in  32  fetched word, valid when `Inst_Valid`=1
- `Inst_Valid`  in  1  fetch data valid (one-cycle pulse)
- `Inst_Req`  out  1  fetch request, held until `Inst_Valid`
- `Mem_Ready`  in  1  data memory access complete (one-cycle pulse)
- `Zero`  in  1  ALU zero flag
- `ALUop`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 011 LUI, 100 SLTU, 101 SLT, 111 SLL
- `sa`  out  5  IR[10:6]
- `IR`  out  32  latched instruction register
- `ALUSrcA`  out  1  0=PC, 1=rs
- `ALUSrcB`  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- `PCSource`  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- `PCWrite`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`  out  1 each  strobes
- `RegDst`  out  1  0=rt, 1=rd
- `MemtoReg`  out  1  0=ALUOut, 1=memory data
- `Illegal`  out  1  one-cycle pulse in ID for an unsupported opcode/funct

## Operation

- States: RST, IF, ID, EX, MEM, WB. Registered state, registered `IR`. All other outputs are decoded combinationally from state, `IR` and the inputs.
- RST: entered asynchronously while `resetn`=0. All outputs are 0 and `IR`=0. Moves to IF on the first clock edge after `resetn`=1.
- IF:
  - `Inst_Req`=1, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=010, `PCSource`=00.
  - When `Inst_Valid`=1, assert `IRWrite` and `PCWrite` that same cycle, latch `Instruction` into `IR`, and go to ID.
  - Otherwise stay in IF with `PCWrite`=0.
- ID:
  - Compute the branch target: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=010.
  - j (000010): `PCWrite`=1, `PCSource`=10, then go to IF.
  - Unsupported encoding: pulse `Illegal`, go to IF (treated as NOP).
  - All other instructions go to EX.
- EX:
  - R-type (opcode 0): `ALUSrcA`=1, `ALUSrcB`=00, `ALUop` from funct: 100001→010, 100011→110, 100100→000, 100101→001, 101010→101, 101011→100, 000000→111 (SLL). Go to WB.
  - addiu 001001→010, lui 001111→011: `ALUSrcB`=10, then go to WB.
  - lw 100011 / sw 101011: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=010, then go to MEM.
  - beq 000100 / bne 000101: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=110, `PCSource`=01. `PCWrite`=`Zero` for beq and `~Zero` for bne. Go to IF.
- MEM:
  - lw holds `MemRead`=1 and sw holds `MemWrite`=1 until `Mem_Ready`.
  - On `Mem_Ready`: lw goes to WB, sw goes to IF.
- WB:
  - `RegWrite`=1 for exactly one cycle, then go to IF.
  - `RegDst`=1 for R-type, else 0. `MemtoReg`=1 only for lw.
- `IR` changes only on an IF cycle with `Inst_Valid`=1.
- `ALUop` defaults to 010 in any state not listed above.

## Timing

- Cycles from IF acceptance to the next IF with zero wait: j 2, beq/bne 3, R-type/addiu/lui 4, sw 4, lw 5. Each wait cycle on `Inst_Valid`/`Mem_Ready` adds exactly one cycle.
- `Inst_Valid` arriving in any state other than IF is ignored.
- `Mem_Ready` arriving outside MEM is ignored.
- `Inst_Valid` in the same cycle that IF is entered from RST is not possible, because `Inst_Req`=0 in RST.
- Reset asserted mid-instruction aborts at once: all strobes drop asynchronously and no partial write completes after reset.
- At most one of `PCWrite`/`RegWrite`/`MemWrite` is high in any cycle.
- SLL with sa=0 is a legal NOP and still performs WB.

## Test plan

- Reset, then release; `Inst_Valid` 3 cycles after `Inst_Req` with addu $3,$1,$2 (0x00221821) -> `Inst_Req` high from cycle 1 after release, `IRWrite`/`PCWrite` on acceptance, EX `ALUop`=010, WB `RegWrite`=1, `RegDst`=1, 4 cycles total.
- beq with `Zero`=1, then again with `Zero`=0 -> `PCWrite`=1 with `PCSource`=01 in EX only in the first case; 3 cycles each. Repeat with bne and check the inverse.
- lw with `Mem_Ready` delayed 4 cycles -> `MemRead` held exactly 4 cycles, then one WB cycle with `MemtoReg`=1 and `RegWrite`=1. sw -> `MemWrite` held until `Mem_Ready`, no WB.
- Sweep every R-type funct plus addiu/lui/slt/sltu/sll sa=5 -> `ALUop` values as listed and `sa`=5; opcode 0x3F -> `Illegal` pulse in ID, no write strobes, return to IF.
- Assert `resetn`=0 during MEM of sw -> `MemWrite` drops the same cycle; after release the sequence restarts at RST→IF with `IR`=0.
- Randomised `Inst_Valid`/`Mem_Ready` strobes outside IF/MEM -> no state change. One-hot check on the write strobes every cycle.
